lcd_hex_writer: RTL and testbench

//  Drives the HD44780-compatible character LCD from the display-select stage outputs.
//  - Takes an 8-bit selector/address code and a 32-bit value, already chosen by the upstream mux.
//  - Runs the LCD power-up/init sequence, then refreshes the screen continuously:
//    - line 1 shows "A=hh";
//    - line 2 shows "D=hhhhhhhh".
//  - Each hex nibble is converted to upper-case ASCII.
//  - Sits between the display-select mux and the board LCD pins.

---
 rtl/lcd_hex_writer.sv | 198 +++++++++++++++++++
 tb/tb_lcd_hex_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: HD44780 character LCD driver. After power-up and init it
// refreshes the screen forever with "A=hh" on line 1 and "D=hhhhhhhh" on
// line 2, taken from a snapshot of hex_in/data_in latched once per frame.
module lcd_hex_writer #(
  parameter int POWERUP_CYC = 750000,
  parameter int EN_CYC      = 25,
  parameter int CMD_CYC     = 2500,
  parameter int CLR_CYC     = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  hex_in,
  input  logic [31:0] data_in,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        frame_done
);

  // Counter must hold the longest wait without wrapping.
  localparam int MAX_AB  = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
  localparam int MAX_CD  = (EN_CYC > CMD_CYC) ? EN_CYC : CMD_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               init_q, init_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic [7:0]         hex_snap_q, hex_snap_d;
  logic [31:0]        val_snap_q, val_snap_d;
  logic [CNT_W-1:0]   hold_last;
  logic [8:0]         next_byte;

  // Hex nibble to upper-case ASCII.
  function automatic logic [7:0] nibble_ascii(input logic [3:0] n);
    if (n <= 4'd9) nibble_ascii = {4'h3, n};
    else           nibble_ascii = 8'h37 + {4'h0, n};
  endfunction

  // {RS, byte} for position idx of the init sequence or of a refresh frame.
  function automatic logic [8:0] byte_sel(input logic init, input logic [3:0] idx,
                                          input logic [7:0] hx, input logic [31:0] dv);
    logic [2:0]  sh;
    logic [31:0] t;
    sh = 3'(4'd15 - idx);
    t  = dv >> {sh, 2'b00};
    if (init) begin
      case (idx)
        4'd0:    byte_sel = {1'b0, 8'h38};
        4'd1:    byte_sel = {1'b0, 8'h0C};
        4'd2:    byte_sel = {1'b0, 8'h01};
        default: byte_sel = {1'b0, 8'h06};
      endcase
    end else begin
      case (idx)
        4'd0:    byte_sel = {1'b0, 8'h80};
        4'd1:    byte_sel = {1'b1, 8'h41};
        4'd2:    byte_sel = {1'b1, 8'h3D};
        4'd3:    byte_sel = {1'b1, nibble_ascii(hx[7:4])};
        4'd4:    byte_sel = {1'b1, nibble_ascii(hx[3:0])};
        4'd5:    byte_sel = {1'b0, 8'hC0};
        4'd6:    byte_sel = {1'b1, 8'h44};
        4'd7:    byte_sel = {1'b1, 8'h3D};
        default: byte_sel = {1'b1, nibble_ascii(t[3:0])};
      endcase
    end
  endfunction

  // Next-state, counter and output-register logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    init_d     = init_q;
    data_d     = data_q;
    rs_d       = rs_q;
    done_d     = 1'b0;
    hex_snap_d = hex_snap_q;
    val_snap_d = val_snap_q;
    // The clear command needs the long settle time.
    hold_last  = (data_q == 8'h01 && !rs_q) ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == CNT_W'(POWERUP_CYC - 1)) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          init_d  = 1'b1;
          idx_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = '0;
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(EN_CYC - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d = '0;
          if (init_q && idx_q == 4'd3) begin
            state_d = S_LATCH;
            init_d  = 1'b0;
          end else if (!init_q && idx_q == 4'd15) begin
            state_d = S_LATCH;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            idx_d   = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        // Snapshot once so every frame shows a consistent value.
        hex_snap_d = hex_in;
        val_snap_d = data_in;
        state_d    = S_SETUP;
        idx_d      = 4'd0;
        cnt_d      = '0;
      end
      default: begin
        state_d = S_PWRUP;
        cnt_d   = '0;
      end
    endcase

    next_byte = byte_sel(init_d, idx_d, hex_snap_q, val_snap_q);
    if (state_d == S_SETUP) begin
      rs_d   = next_byte[8];
      data_d = next_byte[7:0];
    end
    en_d = (state_d == S_PULSE);
  end

  // Sequencer state and registered LCD outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= 4'd0;
      init_q  <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  // Per-frame input snapshot; only meaningful after the first LATCH.
  always_ff @(posedge clk) begin
    hex_snap_q <= hex_snap_d;
    val_snap_q <= val_snap_d;
  end

  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = en_q;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;
  assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Testbench for lcd_hex_writer with shortened timing parameters.
module tb_lcd_hex_writer;

  localparam int P_PWR = 10;
  localparam int P_EN  = 3;
  localparam int P_CMD = 5;
  localparam int P_CLR = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  hex_in;
  logic [31:0] data_in;
  logic [7:0]  LCD_DATA;
  logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done;

  lcd_hex_writer #(
    .POWERUP_CYC(P_PWR), .EN_CYC(P_EN), .CMD_CYC(P_CMD), .CLR_CYC(P_CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hex_in(hex_in), .data_in(data_in),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pin_viol = 0;

  logic [8:0] cap_q[$];
  int         hi_q[$];
  int         gap_q[$];

  typedef struct {
    logic [7:0]   hex;
    logic [31:0]  data;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[4];

  localparam logic [15:0] RS_FRAME = 16'h7BFF;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] asc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference: the 16 frame bytes written out character by character.
  function automatic logic [127:0] model_frame(input logic [7:0] h, input logic [31:0] d);
    logic [7:0]   b[16];
    logic [127:0] r;
    b[0] = 8'h80; b[1] = "A"; b[2] = "=";
    b[3] = asc(int'(h) / 16); b[4] = asc(int'(h) % 16);
    b[5] = 8'hC0; b[6] = "D"; b[7] = "=";
    for (int k = 0; k < 8; k++) b[8 + k] = asc(int'((d / (32'd1 << (28 - 4 * k))) % 32'd16));
    r = '0;
    for (int k = 0; k < 16; k++) r = {r[119:0], b[k]};
    return r;
  endfunction

  // Bus monitor: records every byte at the EN falling edge plus pulse and gap lengths.
  initial begin
    logic prev_en;
    logic seen_fall;
    int   hi, lo;
    prev_en = 1'b0; seen_fall = 1'b0; hi = 0; lo = 0;
    forever begin
      @(negedge clk);
      if (LCD_RW !== 1'b0 || LCD_ON !== 1'b1 || LCD_BLON !== 1'b1) pin_viol++;
      if (!rst_n) begin
        prev_en = 1'b0; seen_fall = 1'b0; hi = 0; lo = 0;
      end else begin
        if (LCD_EN) begin
          if (!prev_en) begin
            if (seen_fall) gap_q.push_back(lo - 1);
            hi = 0;
          end
          hi++;
        end else begin
          if (prev_en) begin
            cap_q.push_back({LCD_RS, LCD_DATA});
            hi_q.push_back(hi);
            seen_fall = 1'b1;
            lo = 0;
          end
          lo++;
        end
        prev_en = LCD_EN;
      end
    end
  end

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    check({name, "_timeout"}, 128'd0, 128'd1);
  endtask

  task automatic wait_caps(input int n, input string name);
    for (int i = 0; i < 2000; i++) begin
      if (cap_q.size() >= n) return;
      @(negedge clk);
    end
    check({name, "_timeout"}, 128'(cap_q.size()), 128'(n));
  endtask

  task automatic get_frame(output logic [127:0] f, output logic [15:0] r);
    int s;
    f = '0; r = '0;
    s = cap_q.size();
    if (s >= 16)
      for (int k = s - 16; k < s; k++) begin
        f = {f[119:0], cap_q[k][7:0]};
        r = {r[14:0], cap_q[k][8]};
      end
    cap_q.delete();
  endtask

  task automatic count_pwrup(input string name);
    int n = 0;
    while (!LCD_EN && n < 100) begin
      @(negedge clk);
      if (!LCD_EN) n++;
    end
    check(name, 128'(n), 128'(P_PWR));
  endtask

  task automatic frame_check(input string name, input logic [127:0] exp);
    logic [127:0] f;
    logic [15:0]  r;
    get_frame(f, r);
    check({name, "_bytes"}, f, exp);
    check({name, "_rs"}, 128'(r), 128'(RS_FRAME));
  endtask

  initial begin
    logic [127:0] init_got;
    tbl[0] = '{8'h1F, 32'hDEADBEEF, 128'h80413D3146C0443D4445414442454546};
    tbl[1] = '{8'h1F, 32'h01234567, 128'h80413D3146C0443D3031323334353637};
    tbl[2] = '{8'hA9, 32'h00000000, 128'h80413D4139C0443D3030303030303030};
    tbl[3] = '{8'h5C, 32'h89ABCDEF, 128'h80413D3543C0443D3839414243444546};

    // Reset state.
    rst_n = 1'b0; hex_in = 8'h1F; data_in = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done}),
          128'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
    cap_q.delete(); hi_q.delete(); gap_q.delete();
    rst_n = 1'b1;

    // Power-up wait and first byte.
    count_pwrup("pwrup_en_low");
    check("first_byte", 128'({LCD_RS, LCD_DATA}), 128'({1'b0, 8'h38}));

    // Init sequence, pulse width and settle gaps.
    wait_caps(4, "init");
    init_got = '0;
    for (int k = 0; k < 4 && k < cap_q.size(); k++) init_got = {init_got[118:0], cap_q[k]};
    check("init_bytes", init_got, 128'({1'b0, 8'h38, 1'b0, 8'h0C, 1'b0, 8'h01, 1'b0, 8'h06}));
    check("en_width", 128'(hi_q.size() > 0 ? hi_q[0] : -1), 128'(P_EN));
    check("init_gaps", 128'(gap_q.size() >= 3 ? {gap_q[0], gap_q[1], gap_q[2]} : 96'd0),
          128'({P_CMD, P_CMD, P_CLR}));

    // First frame and frame_done pulse width.
    wait_done("frame1");
    frame_check("frame1", 128'h80413D3146C0443D4445414442454546);
    @(negedge clk);
    check("done_width", 128'(frame_done), 128'd0);

    // Mid-frame input change only shows on the following frame.
    wait_done("sync4");
    cap_q.delete();
    wait_caps(8, "mid8");
    data_in = 32'h01234567;
    wait_done("frame4a");
    frame_check("midchg_old", 128'h80413D3146C0443D4445414442454546);
    wait_done("frame4b");
    frame_check("midchg_new", 128'h80413D3146C0443D3031323334353637);

    // Table vectors.
    for (int i = 0; i < 4; i++) begin
      hex_in = tbl[i].hex; data_in = tbl[i].data;
      wait_done("tbl_sync");
      cap_q.delete();
      wait_done("tbl_frame");
      frame_check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Randomized values against the reference model.
    for (int i = 0; i < 6; i++) begin
      hex_in = 8'($urandom); data_in = $urandom;
      wait_done("rnd_sync");
      cap_q.delete();
      wait_done("rnd_frame");
      frame_check($sformatf("rnd%0d", i), model_frame(hex_in, data_in));
    end

    // Reset in the middle of an EN pulse.
    begin
      int n = 0;
      while (!LCD_EN && n < 200) begin @(negedge clk); n++; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_en_drop", 128'({LCD_EN, LCD_DATA}), 128'({1'b0, 8'h00}));
    @(negedge clk);
    cap_q.delete(); hi_q.delete(); gap_q.delete();
    rst_n = 1'b1;
    count_pwrup("rst_pwrup_en_low");
    wait_caps(5, "reinit");
    init_got = '0;
    for (int k = 0; k < 5 && k < cap_q.size(); k++) init_got = {init_got[118:0], cap_q[k]};
    check("reinit_bytes", init_got,
          128'({1'b0, 8'h38, 1'b0, 8'h0C, 1'b0, 8'h01, 1'b0, 8'h06, 1'b0, 8'h80}));

    check("const_pins", 128'(pin_viol), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
